// File: rtl/spike_action_decoder.sv
// Counts output-neuron spikes over a fixed window, picks the neuron with more spikes,
// and scores that choice against the target with one-cycle reward/punish pulses.
module spike_action_decoder #(
    parameter int WIN_LEN = 64,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [1:0]       spike_in,
    input  logic             target,
    output logic             action_valid,
    output logic [1:0]       action,
    output logic             reward,
    output logic             punish,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_DECIDE,
        S_REPORT
    } state_t;

    localparam logic [15:0]      LAST_CYCLE = 16'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_acc0;
    logic [CNT_W-1:0] r_acc1;
    logic [15:0]      r_win_cnt;
    logic [CNT_W-1:0] w_acc0_next;
    logic [CNT_W-1:0] w_acc1_next;
    logic [1:0]       w_action;
    logic [1:0]       w_target_onehot;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (run) w_next_state = S_COUNT;
            S_COUNT: begin
                if (!run)                        w_next_state = S_IDLE;
                else if (r_win_cnt == LAST_CYCLE) w_next_state = S_DECIDE;
            end
            S_DECIDE: w_next_state = S_REPORT;
            S_REPORT: w_next_state = run ? S_COUNT : S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Saturating increments: a full accumulator simply holds its value.
    always_comb begin
        w_acc0_next     = (spike_in[0] && (r_acc0 != CNT_MAX)) ? r_acc0 + CNT_W'(1) : r_acc0;
        w_acc1_next     = (spike_in[1] && (r_acc1 != CNT_MAX)) ? r_acc1 + CNT_W'(1) : r_acc1;
        w_target_onehot = target ? 2'b10 : 2'b01;
        w_action        = 2'b00;
        if (r_acc0 > r_acc1)      w_action = 2'b01;
        else if (r_acc1 > r_acc0) w_action = 2'b10;
    end

    // NOTE: state and datapath registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc0       <= '0;
            r_acc1       <= '0;
            r_win_cnt    <= '0;
            cnt0         <= '0;
            cnt1         <= '0;
            action       <= 2'b00;
            action_valid <= 1'b0;
            reward       <= 1'b0;
            punish       <= 1'b0;
            busy         <= 1'b0;
        end else begin
            action_valid <= 1'b0;
            reward       <= 1'b0;
            punish       <= 1'b0;
            busy         <= (w_next_state != S_IDLE);
            case (r_state)
                S_IDLE, S_REPORT: begin
                    if (w_next_state == S_COUNT) begin
                        r_acc0    <= '0;
                        r_acc1    <= '0;
                        r_win_cnt <= '0;
                    end
                end
                S_COUNT: begin
                    if (run) begin
                        r_acc0    <= w_acc0_next;
                        r_acc1    <= w_acc1_next;
                        r_win_cnt <= r_win_cnt + 16'd1;
                    end
                end
                S_DECIDE: begin
                    action       <= w_action;
                    cnt0         <= r_acc0;
                    cnt1         <= r_acc1;
                    action_valid <= 1'b1;
                    reward       <= (w_action != 2'b00) && (w_action == w_target_onehot);
                    punish       <= (w_action != 2'b00) && (w_action != w_target_onehot);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spike_action_decoder.sv
// Directed bench for spike_action_decoder: table of single windows plus hand-written
// abort, reset, back-to-back and saturation sequences.
module tb_spike_action_decoder;

    localparam int W   = 8;
    localparam int CW  = 4;
    localparam int W32 = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          run;
    logic [1:0]    spike_in;
    logic          target;
    logic          action_valid;
    logic [1:0]    action;
    logic          reward;
    logic          punish;
    logic [CW-1:0] cnt0;
    logic [CW-1:0] cnt1;
    logic          busy;

    logic          run32;
    logic [1:0]    spike32;
    logic          target32;
    logic          valid32;
    logic [1:0]    action32;
    logic          reward32;
    logic          punish32;
    logic [CW-1:0] cnt0_32;
    logic [CW-1:0] cnt1_32;
    logic          busy32;

    spike_action_decoder #(.WIN_LEN(W), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .run(run), .spike_in(spike_in), .target(target),
        .action_valid(action_valid), .action(action), .reward(reward), .punish(punish),
        .cnt0(cnt0), .cnt1(cnt1), .busy(busy)
    );

    spike_action_decoder #(.WIN_LEN(W32), .CNT_W(CW)) dut32 (
        .clk(clk), .reset(reset), .run(run32), .spike_in(spike32), .target(target32),
        .action_valid(valid32), .action(action32), .reward(reward32), .punish(punish32),
        .cnt0(cnt0_32), .cnt1(cnt1_32), .busy(busy32)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0] sp_a;
        int         n_a;
        logic [1:0] sp_b;
        int         n_b;
        logic       tgt;
        int         e_c0;
        int         e_c1;
        logic [1:0] e_act;
        logic       e_rew;
        logic       e_pun;
    } vec_t;

    // Single window from IDLE; target is inverted except in DECIDE, so only the
    // DECIDE-cycle sample can produce the expected reward/punish.
    task automatic window_from_idle(input vec_t v, input string tag);
        int start;
        run = 1'b1; spike_in = 2'b00; target = ~v.tgt;
        tick();
        start = cyc;
        check({tag, ".busy_count"}, 32'(busy), 32'd1);
        for (int i = 0; i < W; i++) begin
            if (i < v.n_a)              spike_in = v.sp_a;
            else if (i < v.n_a + v.n_b) spike_in = v.sp_b;
            else                        spike_in = 2'b00;
            tick();
        end
        spike_in = 2'b11; target = v.tgt;
        check({tag, ".valid_in_decide"}, 32'(action_valid), 32'd0);
        tick();
        target = ~v.tgt;
        check({tag, ".valid"},   32'(action_valid), 32'd1);
        check({tag, ".latency"}, 32'(cyc - start + 1), 32'(W + 2));
        check({tag, ".cnt0"},    32'(cnt0), 32'(v.e_c0));
        check({tag, ".cnt1"},    32'(cnt1), 32'(v.e_c1));
        check({tag, ".action"},  32'(action), 32'(v.e_act));
        check({tag, ".reward"},  32'(reward), 32'(v.e_rew));
        check({tag, ".punish"},  32'(punish), 32'(v.e_pun));
        run = 1'b0; spike_in = 2'b00;
        tick();
        check({tag, ".valid_drop"}, 32'(action_valid), 32'd0);
        check({tag, ".busy_idle"},  32'(busy), 32'd0);
        check({tag, ".rp_drop"},    32'({reward, punish}), 32'd0);
    endtask

    vec_t vecs[7];

    initial begin
        int prev_cyc;
        int seen;

        vecs[0] = '{2'b01, 5, 2'b10, 2, 1'b0, 5, 2, 2'b01, 1'b1, 1'b0};
        vecs[1] = '{2'b01, 5, 2'b10, 2, 1'b1, 5, 2, 2'b01, 1'b0, 1'b1};
        vecs[2] = '{2'b11, 8, 2'b00, 0, 1'b0, 8, 8, 2'b00, 1'b0, 1'b0};
        vecs[3] = '{2'b00, 8, 2'b00, 0, 1'b1, 0, 0, 2'b00, 1'b0, 1'b0};
        vecs[4] = '{2'b10, 3, 2'b01, 3, 1'b0, 3, 3, 2'b00, 1'b0, 1'b0};
        vecs[5] = '{2'b01, 1, 2'b00, 7, 1'b1, 1, 0, 2'b01, 1'b0, 1'b1};
        vecs[6] = '{2'b10, 6, 2'b01, 2, 1'b1, 2, 6, 2'b10, 1'b1, 1'b0};

        reset = 1'b1; run = 1'b0; spike_in = 2'b00; target = 1'b0;
        run32 = 1'b0; spike32 = 2'b00; target32 = 1'b0;
        #2;
        check("reset.valid",  32'(action_valid), 32'd0);
        check("reset.action", 32'(action), 32'd0);
        check("reset.cnt",    32'({cnt0, cnt1}), 32'd0);
        check("reset.rp",     32'({reward, punish}), 32'd0);
        check("reset.busy",   32'(busy), 32'd0);

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("post_reset.busy",  32'(busy), 32'd0);
        check("post_reset.valid", 32'(action_valid), 32'd0);

        for (int k = 0; k < 7; k++) window_from_idle(vecs[k], $sformatf("vec%0d", k));

        // Abort by dropping run at window cycle 4; last result was cnt0=2, cnt1=6, action=10.
        run = 1'b1; spike_in = 2'b01;
        tick();
        for (int i = 0; i < 4; i++) tick();
        run = 1'b0;
        tick();
        check("abort.busy",   32'(busy), 32'd0);
        check("abort.cnt0",   32'(cnt0), 32'd2);
        check("abort.cnt1",   32'(cnt1), 32'd6);
        check("abort.action", 32'(action), 32'(2'b10));
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (action_valid || reward || punish) seen++;
            tick();
        end
        check("abort.no_pulse", 32'(seen), 32'd0);

        // Asynchronous reset at window cycle 4, applied between clock edges.
        run = 1'b1; spike_in = 2'b01;
        tick();
        for (int i = 0; i < 4; i++) tick();
        #2;
        reset = 1'b1;
        #1;
        check("midreset.busy",   32'(busy), 32'd0);
        check("midreset.cnt",    32'({cnt0, cnt1}), 32'd0);
        check("midreset.action", 32'(action), 32'd0);
        check("midreset.pulses", 32'({action_valid, reward, punish}), 32'd0);
        @(negedge clk);
        run = 1'b0; spike_in = 2'b00;
        reset = 1'b0;
        tick(); tick();
        check("midreset.stay_idle", 32'(busy), 32'd0);

        // Three back-to-back windows; 10 is driven in DECIDE/REPORT and must be ignored.
        run = 1'b1; target = 1'b0; spike_in = 2'b00;
        tick();
        prev_cyc = 0;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < W; i++) begin
                spike_in = (i <= k) ? 2'b01 : 2'b00;
                tick();
            end
            spike_in = 2'b10;
            check($sformatf("b2b%0d.valid_decide", k), 32'(action_valid), 32'd0);
            tick();
            check($sformatf("b2b%0d.valid", k),  32'(action_valid), 32'd1);
            check($sformatf("b2b%0d.cnt0", k),   32'(cnt0), 32'(k + 1));
            check($sformatf("b2b%0d.cnt1", k),   32'(cnt1), 32'd0);
            check($sformatf("b2b%0d.action", k), 32'(action), 32'(2'b01));
            check($sformatf("b2b%0d.reward", k), 32'(reward), 32'd1);
            if (k > 0) check($sformatf("b2b%0d.spacing", k), 32'(cyc - prev_cyc), 32'(W + 2));
            prev_cyc = cyc;
            if (k == 2) run = 1'b0;
            tick();
            if (k < 2) check($sformatf("b2b%0d.busy_next", k), 32'(busy), 32'd1);
        end
        check("b2b.busy_end", 32'(busy), 32'd0);

        // Saturation on the 32-cycle instance with 4-bit counters.
        run32 = 1'b1; spike32 = 2'b01; target32 = 1'b0;
        tick();
        for (int i = 0; i < W32; i++) tick();
        spike32 = 2'b11;
        tick();
        check("sat.valid",  32'(valid32), 32'd1);
        check("sat.cnt0",   32'(cnt0_32), 32'd15);
        check("sat.cnt1",   32'(cnt1_32), 32'd0);
        check("sat.action", 32'(action32), 32'(2'b01));
        check("sat.reward", 32'({reward32, punish32}), 32'(2'b10));
        run32 = 1'b0; spike32 = 2'b00;
        tick();
        check("sat.busy_idle", 32'(busy32), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spike_action_decoder.md
SPIKE_ACTION_DECODER -- requirements
Module: spike_action_decoder

Interface
REQ-001 SHALL have parameter WIN_LEN, default 64: length of the decision window in clock cycles, legal range 2..65535.
REQ-002 SHALL have parameter CNT_W, default 8: width of each spike counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port run, input, 1 bit: enable for decision windows, driven by the same run signal that enables the network.
REQ-006 SHALL have port spike_in, input, 2 bits: output spike vector of the hippocampal network; bit i is the spike of output neuron i.
REQ-007 SHALL have port target, input, 1 bit: index of the correct output neuron, sampled in DECIDE.
REQ-008 SHALL have port action_valid, output, 1 bit: one-cycle pulse marking a completed decision.
REQ-009 SHALL have port action, output, 2 bits: 2'b01 = neuron 0 won, 2'b10 = neuron 1 won, 2'b00 = no decision.
REQ-010 SHALL have port reward, output, 1 bit: one-cycle pulse, decision matched target.
REQ-011 SHALL have port punish, output, 1 bit: one-cycle pulse, decision mismatched target.
REQ-012 SHALL have ports cnt0 and cnt1, output, CNT_W bits each: final spike counts of the last completed window.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, COUNT, DECIDE and REPORT.
REQ-015 IDLE: on a clock edge with run=1, SHALL go to COUNT and clear the internal counters and the window counter to 0.
REQ-016 COUNT: on each edge, SHALL add spike_in[0] to acc0 and spike_in[1] to acc1, and increment the window counter.
REQ-017 COUNT: the accumulators SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-018 COUNT: the edge on which the window counter equals WIN_LEN-1 SHALL still count spikes and then go to DECIDE; exactly WIN_LEN cycles are sampled.
REQ-019 COUNT: run=0 on any edge SHALL abort to IDLE; no pulses are issued and cnt0/cnt1/action keep their previous values.
REQ-020 DECIDE: action SHALL be 01 if acc0>acc1, 10 if acc1>acc0, and 00 if acc0==acc1 (including both zero).
REQ-021 DECIDE: SHALL sample target and copy acc0/acc1 into cnt0/cnt1, then go to REPORT.
REQ-022 DECIDE: run=0 SHALL NOT abort the decision.
REQ-023 REPORT: action_valid SHALL be 1 for exactly this one cycle.
REQ-024 REPORT: reward SHALL be 1 when action is one-hot and equals (1<<target); punish SHALL be 1 when action is one-hot and differs from it; both SHALL be 0 when action=00.
REQ-025 REPORT: reward and punish SHALL never be high together.
REQ-026 REPORT exit: if run=1, SHALL go to COUNT with the counters cleared, making windows back-to-back with a 2-cycle gap (DECIDE and REPORT, whose spikes are ignored); if run=0, SHALL go to IDLE.
REQ-027 Spikes arriving in IDLE, DECIDE or REPORT SHALL be ignored.
REQ-028 Latency: the first action_valid pulse SHALL occur WIN_LEN+2 cycles after the IDLE->COUNT edge.
REQ-029 action_valid, action, reward, punish, cnt0, cnt1 and busy SHALL all be registered outputs.

Reset
REQ-030 When reset=1 at any time (including mid-window), the state SHALL be forced to IDLE.
REQ-031 Reset SHALL clear acc0, acc1, the window counter, cnt0, cnt1 and action to 0, and drive action_valid, reward, punish and busy to 0.
REQ-032 After reset is released, the block SHALL stay in IDLE until a clock edge with run=1.

Verification (WIN_LEN=8, CNT_W=4)
REQ-033 run=1 held; spike_in=01 for 5 window cycles, 10 for 2; target=0 -> cnt0=5, cnt1=2, action=01, reward pulse, punish=0, action_valid 10 cycles after start.
REQ-034 Same window with target=1 -> action=01, punish pulse, reward=0.
REQ-035 spike_in=11 for all 8 cycles -> cnt0=cnt1=8, action=00, no reward or punish, action_valid still pulses.
REQ-036 WIN_LEN=32, CNT_W=4, spike_in=01 every cycle -> cnt0=15 (saturated), cnt1=0, action=01.
REQ-037 Mid-window checks, one scenario each:
- run dropped at window cycle 4 -> IDLE, no action_valid, cnt0/cnt1 unchanged.
- reset asserted at window cycle 4 -> all outputs 0 immediately without waiting for a clock edge.
REQ-038 run held for 3 windows -> action_valid pulses spaced exactly WIN_LEN+2=10 cycles apart, and spikes in the DECIDE/REPORT cycles are not counted.
